// File: rtl/incrementer_pkg.sv
// -----------------------------------------------------------------------------
// incrementer_pkg
// Shared definitions for the incrementer counter slice.
//   DEFAULT_WIDTH : default counter data width in bits
//   state_t       : counter FSM states (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package incrementer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : incrementer_pkg

// File: rtl/fulladder.sv
// -----------------------------------------------------------------------------
// fulladder
// One-bit full adder cell, the building block of the ripple inc/dec paths.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// -----------------------------------------------------------------------------
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : fulladder

// File: rtl/incrementer.sv
// -----------------------------------------------------------------------------
// incrementer
// Combinational +1: a ripple chain of fulladder cells with operand B tied to 0
// and carry-in tied to 1. Mirror image of the decrement path.
//   a   : value to increment
//   sum : a + 1 modulo 2^WIDTH
//   co  : carry out of the top bit (high only when a is all-ones)
// -----------------------------------------------------------------------------
module incrementer
  import incrementer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fulladder u_fa (
      .a  (a[i]),
      .b  (1'b0),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign co = carry[WIDTH];

endmodule : incrementer

// File: rtl/incrementer_counter.sv
// -----------------------------------------------------------------------------
// incrementer_counter
// Loadable up-counter with IDLE/RUN/DONE control, wrap or one-shot terminal
// behaviour and a sticky overflow flag.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   load, D    : synchronous load of D into Q (highest priority)
//   start      : enter RUN from IDLE or DONE
//   en         : advance Q by one per cycle while in RUN
//   limit      : terminal value, compared live every cycle
//   mode       : 0 = wrap to 0 at limit, 1 = stop at limit and go to DONE
//   clr_ovf    : clear sticky ovf (a simultaneous set wins)
//   Q          : registered count
//   Co         : registered one-cycle wrap/terminal pulse
//   tc         : combinational Q == limit
//   ovf        : sticky overflow
//   busy       : high exactly while in RUN
// -----------------------------------------------------------------------------
module incrementer_counter
  import incrementer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             start,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  input  logic             mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] Q,
  output logic             Co,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] q_plus1;
  logic             all_ones;
  logic             count_step;
  logic             ovf_set;

  // The incrementer's carry out doubles as the all-ones detector.
  incrementer #(.WIDTH(WIDTH)) u_inc (
    .a   (Q),
    .sum (q_plus1),
    .co  (all_ones)
  );

  assign tc         = (Q == limit);
  assign count_step = !load && (state == RUN) && en;
  // Terminal compare takes precedence over the all-ones wrap; the all-ones
  // case only matters when a value above limit was loaded.
  assign ovf_set    = count_step && (tc ? !mode : all_ones);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      Q     <= '0;
      Co    <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every branch sees the
      // pre-edge values of Q/state, as real flops do.
      Co <= 1'b0;

      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;

      if (load) begin
        Q <= D;
      end else if (start && (state != RUN)) begin
        state <= RUN;
        busy  <= 1'b1;
      end else if (count_step) begin
        if (tc) begin
          Co <= 1'b1;
          if (mode) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            Q <= '0;
          end
        end else begin
          // Covers both the normal +1 and the all-ones wrap to 0.
          Q  <= q_plus1;
          Co <= all_ones;
        end
      end
    end
  end

endmodule : incrementer_counter

// File: tb/tb_incrementer_counter.sv
// -----------------------------------------------------------------------------
// tb_incrementer_counter
// Directed-vector bench for incrementer_counter (WIDTH = 4).
// -----------------------------------------------------------------------------
module tb_incrementer_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [W-1:0] d;
  logic         start;
  logic         en;
  logic [W-1:0] limit;
  logic         mode;
  logic         clr_ovf;
  logic [W-1:0] q;
  logic         co;
  logic         tc;
  logic         ovf;
  logic         busy;

  int vectors     = 0;
  int miscompares = 0;

  incrementer_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .D       (d),
    .start   (start),
    .en      (en),
    .limit   (limit),
    .mode    (mode),
    .clr_ovf (clr_ovf),
    .Q       (q),
    .Co      (co),
    .tc      (tc),
    .ovf     (ovf),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input int eq, input int eco,
                              input int eovf, input int ebusy);
    check({tag, ".Q"},    32'(q),    32'(eq));
    check({tag, ".Co"},   32'(co),   32'(eco));
    check({tag, ".ovf"},  32'(ovf),  32'(eovf));
    check({tag, ".busy"}, 32'(busy), 32'(ebusy));
  endtask

  // Reset pulse placed mid-cycle, away from the clock edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Expected Q/Co/ovf per cycle for the wrap run (limit 3, mode 0).
  int wrap_q   [5] = '{1, 2, 3, 0, 1};
  int wrap_co  [5] = '{0, 0, 0, 1, 0};
  int wrap_ovf [5] = '{0, 0, 0, 1, 1};
  // Expected Q/Co/ovf per cycle for the above-limit run (limit 4, D = 14).
  int abv_q    [7] = '{15, 0, 1, 2, 3, 4, 0};
  int abv_co   [7] = '{0, 1, 0, 0, 0, 0, 1};

  initial begin
    rst_n = 1'b0; load = 1'b0; d = '0; start = 1'b0; en = 1'b0;
    limit = '0; mode = 1'b0; clr_ovf = 1'b0;

    // Reset state, tc against Q = 0 while held in reset.
    #3;
    expect_state("rst", 0, 0, 0, 0);
    check("rst.tc_lim0", 32'(tc), 1);
    limit = 4'd5;
    #1;
    check("rst.tc_lim5", 32'(tc), 0);
    #5;
    rst_n = 1'b1;

    // en alone after reset does nothing.
    en = 1'b1;
    step();
    expect_state("idle_en", 0, 0, 0, 0);
    en = 1'b0;

    // Wrap mode: limit 3, start, en held five cycles.
    limit = 4'd3; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    expect_state("wrap_start", 0, 0, 0, 1);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_state($sformatf("wrap%0d", i), wrap_q[i], wrap_co[i], wrap_ovf[i], 1);
    end
    en = 1'b0;

    // start in RUN is ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    expect_state("run_start", 1, 0, 1, 1);

    // Load in RUN keeps the state, then asynchronous reset mid-count.
    load = 1'b1; d = 4'd5;
    step();
    load = 1'b0;
    expect_state("run_load", 5, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("async_rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    en = 1'b1;
    step();
    en = 1'b0;
    expect_state("post_rst_idle", 0, 0, 0, 0);

    // Sticky clear: clr_ovf on the wrap cycle loses, later it clears.
    start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b1;
    step(); step(); step();
    check("sticky_q3", 32'(q), 3);
    check("sticky_tc", 32'(tc), 1);
    clr_ovf = 1'b1;
    step();
    expect_state("sticky_wrap", 0, 1, 1, 1);
    en = 1'b0;
    step();
    clr_ovf = 1'b0;
    expect_state("sticky_clr", 0, 0, 0, 1);

    // Priority: load + start + en from IDLE -> only the load acts.
    pulse_reset();
    load = 1'b1; d = 4'd2; start = 1'b1; en = 1'b1;
    step();
    load = 1'b0; en = 1'b0;
    expect_state("prio_load", 2, 0, 0, 0);
    step();
    start = 1'b0;
    expect_state("prio_start", 2, 0, 0, 1);

    // One-shot: limit 9, load 7, count to 9 then DONE.
    pulse_reset();
    limit = 4'd9; mode = 1'b1; load = 1'b1; d = 4'd7;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0; en = 1'b1;
    expect_state("os_start", 7, 0, 0, 1);
    step();
    expect_state("os_8", 8, 0, 0, 1);
    step();
    expect_state("os_9", 9, 0, 0, 1);
    check("os_tc", 32'(tc), 1);
    step();
    expect_state("os_term", 9, 1, 0, 0);
    step();
    expect_state("os_done_en", 9, 0, 0, 0);
    en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    expect_state("os_restart", 9, 0, 0, 1);

    // Above-limit load, wrap mode: 15 -> 0 via all-ones, then to limit.
    pulse_reset();
    limit = 4'd4; mode = 1'b0; load = 1'b1; d = 4'd14;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      expect_state($sformatf("abv%0d", i), abv_q[i], abv_co[i], (i == 0) ? 0 : 1, 1);
    end
    en = 1'b0;

    // Above-limit load in one-shot mode still wraps, sets ovf, stays RUN.
    pulse_reset();
    limit = 4'd4; mode = 1'b1; load = 1'b1; d = 4'd15;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0; en = 1'b1;
    step();
    en = 1'b0;
    expect_state("abv_os", 0, 1, 1, 1);

    // limit changes reach tc in the same cycle.
    limit = 4'd0;
    #1;
    check("lim_tc_hit", 32'(tc), 1);
    limit = 4'd7;
    #1;
    check("lim_tc_miss", 32'(tc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_incrementer_counter

// File: doc/incrementer_counter.md
INCREMENTER_COUNTER -- requirements
Module: incrementer_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the counter data width in bits.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port load  input  1  synchronous load of D into Q.
REQ-005 The block SHALL have port D  input  WIDTH  load value.
REQ-006 The block SHALL have port start  input  1  pulse that enters RUN from IDLE or DONE.
REQ-007 The block SHALL have port en  input  1  count enable, advances Q by +1 per cycle in RUN.
REQ-008 The block SHALL have port limit  input  WIDTH  terminal value; sampled each cycle.
REQ-009 The block SHALL have port mode  input  1  0 = wrap (free-run), 1 = one-shot (stop at limit).
REQ-010 The block SHALL have port clr_ovf  input  1  clears sticky ovf.
REQ-011 The block SHALL have port Q  output  WIDTH  registered count.
REQ-012 The block SHALL have port Co  output  1  registered one-cycle wrap/terminal pulse.
REQ-013 The block SHALL have port tc  output  1  combinational, high when Q == limit.
REQ-014 The block SHALL have port ovf  output  1  sticky, set on every wrap in mode 0.
REQ-015 The block SHALL have port busy  output  1  high exactly while state is RUN.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DONE; busy SHALL be 1 only in RUN.
REQ-017 Per-cycle priority SHALL be load > start > en.
REQ-018 load SHALL set Q <= D next cycle in any state, leave the state unchanged and force Co = 0.
REQ-019 start without load SHALL move IDLE or DONE to RUN without changing Q; in RUN it SHALL be ignored.
REQ-020 In RUN with en = 1, no load, and Q != limit and Q != all-ones, Q SHALL become Q+1 next cycle with Co = 0.
REQ-021 In RUN with en = 1, no load, and Q == limit in mode 0, Q SHALL become 0, Co SHALL pulse 1 for one cycle, and ovf SHALL set.
REQ-022 In RUN with en = 1, no load, and Q == limit in mode 1, Q SHALL hold, Co SHALL pulse 1 for one cycle, and the state SHALL become DONE.
REQ-023 In RUN with en = 1 and Q == all-ones while limit < Q (value loaded above limit), Q SHALL wrap to 0 with Co = 1 for one cycle; ovf SHALL set in either mode, and the state SHALL stay RUN.
REQ-024 en SHALL be ignored in IDLE and DONE: Q holds and Co = 0.
REQ-025 Latency from an accepted en to the Q update and Co SHALL be exactly one clock.
REQ-026 When ovf set and clr_ovf coincide, set SHALL win; otherwise clr_ovf SHALL clear ovf next cycle.
REQ-027 A change of limit SHALL take effect in the same cycle for tc and for the terminal compare.
REQ-028 The increment SHALL be modulo 2^WIDTH with no reliance on out-of-width bits.

Reset
REQ-029 Asserting rst_n low SHALL immediately force Q = 0, Co = 0, ovf = 0, busy = 0 and state IDLE, including mid-count.
REQ-030 After rst_n deasserts, the block SHALL take no action until load or start arrives.
REQ-031 tc SHALL reflect Q = 0 against limit while in reset.

Structure
REQ-032 A shared package incrementer_pkg SHALL hold the WIDTH default and the state enumeration (IDLE, RUN, DONE).
REQ-033 A combinational sub-module incrementer SHALL compute Q+1 and carry as a ripple chain of the team's existing fulladder cells (operand B = 0, carry-in = 1); it SHALL be the mirror of the team's decrement path.
REQ-034 Register, FSM and compare logic SHALL live in incrementer_counter only.

Verification
REQ-035 Reset mid-count: with Q = 5 in RUN, pulse rst_n low -> Q = 0, busy = 0, ovf = 0 asynchronously, state IDLE.
REQ-036 Wrap mode: limit = 3, mode = 0, start, en held for 5 cycles -> Q = 1,2,3,0,1; Co high on the cycle Q becomes 0; ovf = 1 after the wrap.
REQ-037 One-shot: limit = 9, mode = 1, load D = 7, start, en held -> Q = 8, 9, then holds at 9; Co pulses once; busy falls; further en gives no change.
REQ-038 Priority: in one cycle, load = 1 with D = 2, start = 1 and en = 1 from IDLE -> Q = 2, state remains IDLE; next cycle start alone -> RUN.
REQ-039 Above-limit load: limit = 4, load D = 14, start, en held -> Q = 15, then 0 with Co = 1 and ovf = 1, then 1, 2, 3, 4, 0.
REQ-040 Sticky clear: ovf = 1 and clr_ovf asserted on a wrap cycle -> ovf stays 1; clr_ovf on a non-wrap cycle -> ovf = 0.
